// File: rtl/s2mm_sched_pkg.sv
// Shared types and defaults for the S2MM frame scheduler.
// Holds the scheduler state encoding and the default ring-depth constants.
package s2mm_sched_pkg;

  localparam int DEFAULT_MAX_BUFS  = 8;
  localparam int DEFAULT_IDX_WIDTH = $clog2(DEFAULT_MAX_BUFS);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT_DONE,
    REPORT,
    FAULT
  } sched_state_t;

endpackage

// File: rtl/s2mm_addr_ring.sv
// Buffer ring bookkeeping: write index with strided address accumulator and read index.
// The address advances by repeated addition, and wraps back to base, so no multiplier is needed.
module s2mm_addr_ring
  import s2mm_sched_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int IDX_WIDTH      = DEFAULT_IDX_WIDTH
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      load,
  input  logic                      advance,
  input  logic                      rel,
  input  logic [AXI_ADDR_WIDTH-1:0] load_base,
  input  logic [AXI_ADDR_WIDTH-1:0] base,
  input  logic [AXI_ADDR_WIDTH-1:0] stride,
  input  logic [IDX_WIDTH:0]        num_bufs,
  output logic [IDX_WIDTH-1:0]      wr_idx,
  output logic [AXI_ADDR_WIDTH-1:0] addr
);

  localparam logic [IDX_WIDTH:0]   CNT_ONE = (IDX_WIDTH + 1)'(1);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE = IDX_WIDTH'(1);

  logic [IDX_WIDTH-1:0] rd_idx;
  logic [IDX_WIDTH:0]   last_idx;
  logic                 wr_last;
  logic                 rd_last;

  assign last_idx = num_bufs - CNT_ONE;
  assign wr_last  = ({1'b0, wr_idx} == last_idx);
  assign rd_last  = ({1'b0, rd_idx} == last_idx);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_idx <= '0;
      rd_idx <= '0;
      addr   <= '0;
    end else if (load) begin
      wr_idx <= '0;
      rd_idx <= '0;
      addr   <= load_base;
    end else begin
      if (advance) begin
        if (wr_last) begin
          wr_idx <= '0;
          addr   <= base;
        end else begin
          wr_idx <= wr_idx + IDX_ONE;
          addr   <= addr + stride;
        end
      end
      if (rel) begin
        rd_idx <= rd_last ? '0 : rd_idx + IDX_ONE;
      end
    end
  end

endmodule

// File: rtl/s2mm_frame_sched.sv
// Sequences the FIFO-to-AXI-MM burst writer over a ring of strided frame buffers with release credits.
// Optional watchdog on the writer's DONE: define S2MM_SCHED_WATCHDOG_EN.
module s2mm_frame_sched
  import s2mm_sched_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int LEN_WIDTH      = 32,
  parameter int MAX_BUFS       = DEFAULT_MAX_BUFS,
  parameter int IDX_WIDTH      = $clog2(MAX_BUFS),
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      enable,
  input  logic [AXI_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [AXI_ADDR_WIDTH-1:0] cfg_stride,
  input  logic [LEN_WIDTH-1:0]      cfg_frame_len,
  input  logic [IDX_WIDTH:0]        cfg_num_bufs,
  output logic [AXI_ADDR_WIDTH-1:0] wr_base_addr,
  output logic [LEN_WIDTH-1:0]      wr_transfer_len,
  output logic                      wr_start,
  input  logic                      wr_busy,
  input  logic                      wr_done,
  output logic                      frm_done,
  output logic [IDX_WIDTH-1:0]      frm_idx,
  input  logic                      rel_valid,
  output logic [IDX_WIDTH:0]        fill_count,
  output logic                      running,
  output logic                      cfg_err,
  output logic                      timeout
);

  localparam logic [IDX_WIDTH:0] MAX_BUFS_CNT = (IDX_WIDTH + 1)'(MAX_BUFS);
  localparam logic [IDX_WIDTH:0] CNT_ONE      = (IDX_WIDTH + 1)'(1);

  sched_state_t              state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] base_q, stride_q, ring_addr;
  logic [LEN_WIDTH-1:0]      len_q;
  logic [IDX_WIDTH:0]        num_bufs_q, fill_q;
  logic [IDX_WIDTH-1:0]      wr_idx;
  logic                      cfg_bad, start_run, report, rel_ok;

  assign cfg_bad   = (cfg_frame_len == '0) || (cfg_num_bufs == '0) || (cfg_num_bufs > MAX_BUFS_CNT);
  assign start_run = (state_q == IDLE) && enable && !cfg_bad;
  assign report    = (state_q == REPORT);
  // A release against an empty ring, or while parked in IDLE, has nothing to free.
  assign rel_ok     = rel_valid && (state_q != IDLE) && (fill_q != '0);
  assign fill_count = fill_q;

`ifdef S2MM_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            wd_expired;
  logic            timeout_q;

  assign wd_expired = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout    = timeout_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q <= (state_q == WAIT_DONE) ? wd_cnt_q + WD_W'(1) : '0;
      if (state_q == WAIT_DONE && state_d == FAULT) begin
        timeout_q <= 1'b1;
      end else if (state_q == IDLE) begin
        timeout_q <= 1'b0;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: ARESETn is sampled on the ACLK edge only (synchronous), so it stays out of the sensitivity list.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_run) state_d = CHECK;
      CHECK: begin
        if (!enable)                    state_d = IDLE;
        else if (fill_q == num_bufs_q)  state_d = CHECK;
        else if (!wr_busy)              state_d = ISSUE;
      end
      ISSUE:     state_d = WAIT_DONE;
      // The writer cannot abort, so enable is ignored until its frame finishes.
      WAIT_DONE: begin
        if (wr_done) state_d = REPORT;
`ifdef S2MM_SCHED_WATCHDOG_EN
        else if (wd_expired) state_d = FAULT;
`endif
      end
      REPORT:    state_d = CHECK;
`ifdef S2MM_SCHED_WATCHDOG_EN
      FAULT:     if (!enable) state_d = IDLE;
`endif
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_start = (state_q == ISSUE);
    frm_done = report;
    frm_idx  = report ? wr_idx : '0;
    running  = (state_q != IDLE);
  end

  // NOTE: registered state uses non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      base_q          <= '0;
      stride_q        <= '0;
      len_q           <= '0;
      num_bufs_q      <= '0;
      fill_q          <= '0;
      wr_base_addr    <= '0;
      wr_transfer_len <= '0;
      cfg_err         <= 1'b0;
    end else begin
      if (start_run) begin
        base_q     <= cfg_base_addr;
        stride_q   <= cfg_stride;
        len_q      <= cfg_frame_len;
        num_bufs_q <= cfg_num_bufs;
        fill_q     <= '0;
      end else if (report && !rel_ok) begin
        fill_q <= fill_q + CNT_ONE;
      end else if (!report && rel_ok) begin
        fill_q <= fill_q - CNT_ONE;
      end

      // Writer command is captured once per frame and held until its DONE.
      if (state_q == CHECK && state_d == ISSUE) begin
        wr_base_addr    <= ring_addr;
        wr_transfer_len <= len_q;
      end

      if (!enable)                        cfg_err <= 1'b0;
      else if (state_q == IDLE && cfg_bad) cfg_err <= 1'b1;
    end
  end

  s2mm_addr_ring #(
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
    .IDX_WIDTH     (IDX_WIDTH)
  ) u_ring (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .load     (start_run),
    .advance  (report),
    .rel      (rel_ok),
    .load_base(cfg_base_addr),
    .base     (base_q),
    .stride   (stride_q),
    .num_bufs (num_bufs_q),
    .wr_idx   (wr_idx),
    .addr     (ring_addr)
  );

endmodule

// File: tb/tb_s2mm_frame_sched.sv
// Directed bench for s2mm_frame_sched with a behavioural burst writer (START -> BUSY -> DONE).
// The watchdog scenario is compiled in when S2MM_SCHED_WATCHDOG_EN is defined.
module tb_s2mm_frame_sched;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        enable;
  logic [31:0] cfg_base_addr, cfg_stride, cfg_frame_len;
  logic [3:0]  cfg_num_bufs;
  logic [31:0] wr_base_addr, wr_transfer_len;
  logic        wr_start, wr_busy, wr_done, frm_done;
  logic [2:0]  frm_idx;
  logic        rel_valid;
  logic [3:0]  fill_count;
  logic        running, cfg_err, timeout;

  int          errors = 0;
  int          checks = 0;
  int          start_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] addr_q[$];
  bit          hang = 1'b0;

  always #5 ACLK = ~ACLK;

  s2mm_frame_sched #(
    .AXI_ADDR_WIDTH(32),
    .LEN_WIDTH     (32),
    .MAX_BUFS      (8),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .ACLK           (ACLK),
    .ARESETn        (ARESETn),
    .enable         (enable),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_stride     (cfg_stride),
    .cfg_frame_len  (cfg_frame_len),
    .cfg_num_bufs   (cfg_num_bufs),
    .wr_base_addr   (wr_base_addr),
    .wr_transfer_len(wr_transfer_len),
    .wr_start       (wr_start),
    .wr_busy        (wr_busy),
    .wr_done        (wr_done),
    .frm_done       (frm_done),
    .frm_idx        (frm_idx),
    .rel_valid      (rel_valid),
    .fill_count     (fill_count),
    .running        (running),
    .cfg_err        (cfg_err),
    .timeout        (timeout)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Writer model: busy for a few cycles after START, then a one-cycle DONE (held off while hang is set).
  initial begin
    wr_busy = 1'b0;
    wr_done = 1'b0;
    forever begin
      tick();
      if (wr_start) begin
        wr_busy = 1'b1;
        tick();
        tick();
        while (hang) tick();
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        wr_busy = 1'b0;
      end
    end
  end

  // Monitor samples later in the cycle than the stimulus tasks.
  initial begin
    forever begin
      @(posedge ACLK);
      #2;
      if (wr_start) begin
        start_cnt++;
        addr_q.push_back(wr_base_addr);
      end
      if (frm_done) done_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic set_cfg(input logic [31:0] len, input logic [3:0] nb);
    cfg_base_addr = 32'h1000;
    cfg_stride    = 32'h400;
    cfg_frame_len = len;
    cfg_num_bufs  = nb;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!wr_start && n < 40) begin tick(); n++; end
    checks++;
    if (!wr_start) begin
      errors++;
      $display("FAIL %s: wr_start not seen within 40 cycles", tag);
    end
  endtask

  task automatic wait_frm(input string tag);
    int n = 0;
    while (!frm_done && n < 60) begin tick(); n++; end
    checks++;
    if (!frm_done) begin
      errors++;
      $display("FAIL %s: frm_done not seen within 60 cycles", tag);
    end
  endtask

  task automatic go_idle(input string tag);
    int n = 0;
    enable    = 1'b0;
    rel_valid = 1'b0;
    hang      = 1'b0;
    tick();
    while ((running || wr_busy) && n < 60) begin tick(); n++; end
    checks++;
    if (running || wr_busy) begin
      errors++;
      $display("FAIL %s_idle: running=%0b busy=%0b required 0 0", tag, running, wr_busy);
    end
  endtask

  task automatic test_reset();
    ARESETn   = 1'b0;
    enable    = 1'b0;
    rel_valid = 1'b0;
    set_cfg(32'd64, 4'd4);
    repeat (3) tick();
    checks++; if (wr_start !== 1'b0) begin errors++; $display("FAIL reset_wr_start: got %0b required 0", wr_start); end
    checks++; if (frm_done !== 1'b0) begin errors++; $display("FAIL reset_frm_done: got %0b required 0", frm_done); end
    checks++; if (frm_idx !== 3'd0) begin errors++; $display("FAIL reset_frm_idx: got %0d required 0", frm_idx); end
    checks++; if (fill_count !== 4'd0) begin errors++; $display("FAIL reset_fill: got %0d required 0", fill_count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b required 0", running); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %0b required 0", cfg_err); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b required 0", timeout); end
    checks++; if (wr_base_addr !== 32'h0) begin errors++; $display("FAIL reset_base: got %0h required 0", wr_base_addr); end
    checks++; if (wr_transfer_len !== 32'h0) begin errors++; $display("FAIL reset_len: got %0h required 0", wr_transfer_len); end
    ARESETn = 1'b1;
    tick();
  endtask

  task automatic test_ring();
    logic [31:0] exp_addr [5];
    logic [2:0]  exp_idx  [5];
    logic [2:0]  idx_q[$];
    bit          pend = 1'b0;
    int          t_done = -1;
    int          gap = -1;
    exp_addr = '{32'h1000, 32'h1400, 32'h1800, 32'h1C00, 32'h1000};
    exp_idx  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    addr_q.delete();
    set_cfg(32'd64, 4'd4);
    enable = 1'b1;
    tick();
    tick();
    checks++; if (wr_start !== 1'b1) begin errors++; $display("FAIL ring_start_latency: wr_start=%0b required 1 two cycles after enable", wr_start); end
    checks++; if (wr_transfer_len !== 32'd64) begin errors++; $display("FAIL ring_len: got %0d required 64", wr_transfer_len); end
    for (int c = 0; c < 300 && idx_q.size() < 5; c++) begin
      tick();
      rel_valid = pend;
      pend = 1'b0;
      if (frm_done) begin
        idx_q.push_back(frm_idx);
        pend = 1'b1;
        if (t_done < 0) t_done = c;
      end
      if (wr_start && t_done >= 0 && gap < 0) gap = c - t_done;
    end
    enable = 1'b0;
    tick();
    rel_valid = pend;
    tick();
    rel_valid = 1'b0;
    go_idle("ring");
    checks++; if (gap !== 2) begin errors++; $display("FAIL ring_frm_to_start: got %0d cycles required 2", gap); end
    checks++; if (addr_q.size() !== 5) begin errors++; $display("FAIL ring_start_count: got %0d required 5", addr_q.size()); end
    checks++; if (idx_q.size() !== 5) begin errors++; $display("FAIL ring_done_count: got %0d required 5", idx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < addr_q.size()) begin
        checks++;
        if (addr_q[i] !== exp_addr[i]) begin errors++; $display("FAIL ring_addr[%0d]: got %0h required %0h", i, addr_q[i], exp_addr[i]); end
      end
      if (i < idx_q.size()) begin
        checks++;
        if (idx_q[i] !== exp_idx[i]) begin errors++; $display("FAIL ring_idx[%0d]: got %0d required %0d", i, idx_q[i], exp_idx[i]); end
      end
    end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL ring_stopped: running=%0b required 0", running); end
  endtask

  task automatic test_stall();
    int s0;
    s0 = start_cnt;
    set_cfg(32'd16, 4'd2);
    enable = 1'b1;
    tick();
    wait_frm("stall_f0");
    tick();
    wait_frm("stall_f1");
    repeat (10) tick();
    checks++; if (fill_count !== 4'd2) begin errors++; $display("FAIL stall_fill: got %0d required 2", fill_count); end
    checks++; if (start_cnt - s0 !== 2) begin errors++; $display("FAIL stall_starts: got %0d required 2", start_cnt - s0); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL stall_running: got %0b required 1", running); end
    rel_valid = 1'b1;
    tick();
    rel_valid = 1'b0;
    checks++; if (fill_count !== 4'd1) begin errors++; $display("FAIL stall_rel_fill: got %0d required 1", fill_count); end
    for (int i = 0; i < 3 && !wr_start; i++) tick();
    checks++; if (wr_start !== 1'b1) begin errors++; $display("FAIL stall_resume: wr_start=%0b required 1 within 3 cycles", wr_start); end
    checks++; if (wr_base_addr !== 32'h1000) begin errors++; $display("FAIL stall_resume_addr: got %0h required 1000", wr_base_addr); end
    tick();
    wait_frm("stall_f2");
    go_idle("stall");
  endtask

  task automatic test_cfg_err();
    logic [31:0] lens [3];
    logic [3:0]  nbs  [3];
    int          s0;
    lens = '{32'd0, 32'd64, 32'd64};
    nbs  = '{4'd4, 4'd0, 4'd9};
    s0 = start_cnt;
    for (int k = 0; k < 3; k++) begin
      set_cfg(lens[k], nbs[k]);
      enable = 1'b1;
      tick();
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_set[%0d]: got %0b required 1", k, cfg_err); end
      repeat (5) tick();
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL cfg_err_idle[%0d]: running=%0b required 0", k, running); end
      enable = 1'b0;
      tick();
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear[%0d]: got %0b required 0", k, cfg_err); end
    end
    checks++; if (start_cnt - s0 !== 0) begin errors++; $display("FAIL cfg_err_no_start: got %0d starts required 0", start_cnt - s0); end
    set_cfg(32'd1, 4'd8);
    enable = 1'b1;
    wait_start("cfg_max_bufs");
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_max_bufs_err: got %0b required 0", cfg_err); end
    tick();
    wait_frm("cfg_max_bufs_f0");
    go_idle("cfg");
  endtask

  task automatic test_enable_drop();
    int s0;
    int frames = 0;
    s0 = start_cnt;
    set_cfg(32'd64, 4'd4);
    enable = 1'b1;
    wait_start("drop_start");
    enable = 1'b0;
    tick();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL drop_wait_running: got %0b required 1", running); end
    for (int c = 0; c < 30; c++) begin
      tick();
      if (frm_done) frames++;
    end
    checks++; if (frames !== 1) begin errors++; $display("FAIL drop_frames: got %0d required 1", frames); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL drop_running: got %0b required 0", running); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL drop_starts: got %0d required 1", start_cnt - s0); end
  endtask

  task automatic test_release_rules();
    set_cfg(32'd8, 4'd2);
    enable = 1'b1;
    tick();
    wait_frm("rel_f0");
    tick();
    checks++; if (fill_count !== 4'd1) begin errors++; $display("FAIL rel_fill_after_f0: got %0d required 1", fill_count); end
    wait_frm("rel_f1");
    rel_valid = 1'b1;
    enable    = 1'b0;
    tick();
    rel_valid = 1'b0;
    checks++; if (fill_count !== 4'd1) begin errors++; $display("FAIL rel_coincident: got %0d required 1", fill_count); end
    tick();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rel_idle: running=%0b required 0", running); end
    rel_valid = 1'b1;
    tick();
    rel_valid = 1'b0;
    checks++; if (fill_count !== 4'd1) begin errors++; $display("FAIL rel_in_idle: got %0d required 1", fill_count); end
    enable = 1'b1;
    tick();
    checks++; if (fill_count !== 4'd0) begin errors++; $display("FAIL rel_restart_fill: got %0d required 0", fill_count); end
    rel_valid = 1'b1;
    tick();
    rel_valid = 1'b0;
    checks++; if (fill_count !== 4'd0) begin errors++; $display("FAIL rel_empty: got %0d required 0", fill_count); end
    wait_frm("rel_f2");
    tick();
    checks++; if (fill_count !== 4'd1) begin errors++; $display("FAIL rel_after_empty: got %0d required 1", fill_count); end
    go_idle("rel");
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    set_cfg(32'd64, 4'd4);
    enable = 1'b1;
    wait_start("rst_start");
    tick();
    ARESETn = 1'b0;
    enable  = 1'b0;
    tick();
    d0 = done_cnt;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_mid_running: got %0b required 0", running); end
    checks++; if (wr_base_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_base: got %0h required 0", wr_base_addr); end
    ARESETn = 1'b1;
    repeat (10) tick();
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rst_mid_stray_done: got %0d frm_done required 0", done_cnt - d0); end
    go_idle("rst");
  endtask

`ifdef S2MM_SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    int n = 0;
    int starts = 0;
    hang = 1'b1;
    set_cfg(32'd64, 4'd4);
    enable = 1'b1;
    wait_start("wd_start");
    while (!timeout && n < 300) begin tick(); n++; end
    checks++; if (n !== 101) begin errors++; $display("FAIL wd_latency: timeout after %0d cycles from START required 101", n); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wr_start) starts++;
    end
    checks++; if (starts !== 0) begin errors++; $display("FAIL wd_fault_start: got %0d starts required 0", starts); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL wd_fault_running: got %0b required 1", running); end
    enable = 1'b0;
    tick();
    tick();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wd_clear: got %0b required 0", timeout); end
    go_idle("wd");
  endtask
`else
  task automatic test_no_watchdog();
    hang = 1'b1;
    set_cfg(32'd64, 4'd4);
    enable = 1'b1;
    wait_start("nowd_start");
    repeat (150) tick();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL nowd_timeout: got %0b required 0", timeout); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL nowd_running: got %0b required 1", running); end
    go_idle("nowd");
  endtask
`endif

  initial begin
    test_reset();
    test_ring();
    test_stall();
    test_cfg_err();
    test_enable_drop();
    test_release_rules();
    test_reset_mid_frame();
`ifdef S2MM_SCHED_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
